// File: rtl/vme_reg_sched.sv
// rtl/vme_reg_sched.sv - VME req/ack access sequencer for the trigger config shadow bank
// Shadow flags/words are committed atomically to the active outputs outside the spill gate.
module vme_reg_sched #(
    parameter int N_FLAG = 15,
    parameter int N_WORD = 58,
    parameter int ADDR_W = 7,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vme_req,
    input  logic                  vme_wr,
    input  logic [ADDR_W-1:0]     vme_addr,
    input  logic [31:0]           vme_wdata,
    output logic                  vme_ack,
    output logic                  vme_err,
    output logic [31:0]           vme_rdata,
    input  logic                  spill_gate,
    output logic [N_FLAG-1:0]     cfg_flags,
    output logic [N_WORD*32-1:0]  cfg_words,
    output logic                  cfg_valid,
    output logic                  commit_pend,
    output logic                  busy
);

    localparam int FIDX_W = (N_FLAG > 1) ? $clog2(N_FLAG) : 1;
    localparam int WIDX_W = (N_WORD > 1) ? $clog2(N_WORD) : 1;
    localparam int CNT_W  = 3;

    localparam logic [ADDR_W-1:0] A_WORD_LO  = ADDR_W'(N_FLAG);
    localparam logic [ADDR_W-1:0] A_WORD_END = ADDR_W'(N_FLAG + N_WORD);
    localparam logic [ADDR_W-1:0] A_CMD      = '1;
    localparam logic [ADDR_W-1:0] A_STATUS   = A_CMD - 1'b1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR      = 2'd1,
        S_RD_WAIT = 2'd2,
        S_REL     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_accept;
    logic               w_wr_done;
    logic               w_rd_done;

    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic               r_ack;
    logic               r_err;
    logic [31:0]        r_rdata;
    logic               r_cfg_valid;
    logic               r_commit_pend;

    logic [N_FLAG-1:0]  r_sh_flags;
    logic [N_FLAG-1:0]  r_act_flags;
    logic [31:0]        r_sh_words  [N_WORD];
    logic [31:0]        r_act_words [N_WORD];

    logic               w_is_flag;
    logic               w_is_word;
    logic               w_is_status;
    logic               w_is_cmd;
    logic               w_wr_err;
    logic               w_rd_err;
    logic [FIDX_W-1:0]  w_flag_idx;
    logic [WIDX_W-1:0]  w_word_idx;
    logic [31:0]        w_rd_val;
    logic               w_commit_fire;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_wr_done   = 1'b0;
        w_rd_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (vme_req) begin
                    w_accept = 1'b1;
                    if (vme_wr) begin
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_RD_WAIT;
                        w_cnt_nxt   = CNT_W'(RD_LAT - 1);
                    end
                end
            end
            S_WR: begin
                w_wr_done   = 1'b1;
                w_state_nxt = S_REL;
            end
            S_RD_WAIT: begin
                if (r_cnt == '0) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = S_REL;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_REL: begin
                if (!vme_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address decode works on the request captured at acceptance.
    always_comb begin
        w_is_flag   = (r_addr < A_WORD_LO);
        w_is_word   = (r_addr >= A_WORD_LO) && (r_addr < A_WORD_END);
        w_is_status = (r_addr == A_STATUS);
        w_is_cmd    = (r_addr == A_CMD);
        w_wr_err    = !(w_is_flag || w_is_word || w_is_cmd);
        w_rd_err    = !(w_is_flag || w_is_word || w_is_status);
        w_flag_idx  = FIDX_W'(r_addr);
        w_word_idx  = WIDX_W'(r_addr - A_WORD_LO);
        w_rd_val    = '0;
        if (w_is_flag) begin
            w_rd_val = {31'b0, r_sh_flags[w_flag_idx]};
        end else if (w_is_word) begin
            w_rd_val = r_sh_words[w_word_idx];
        end else if (w_is_status) begin
            w_rd_val = {30'b0, spill_gate, r_commit_pend};
        end
    end

    assign w_commit_fire = r_commit_pend && !spill_gate;

    // Handshake, request capture and commit bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_ack         <= 1'b0;
            r_err         <= 1'b0;
            r_rdata       <= '0;
            r_cfg_valid   <= 1'b0;
            r_commit_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= vme_addr;
                r_wdata <= vme_wdata;
            end
            r_ack <= w_wr_done | w_rd_done;
            r_err <= (w_wr_done & w_wr_err) | (w_rd_done & w_rd_err);
            if (w_rd_done) begin
                r_rdata <= w_rd_val;
            end
            r_cfg_valid <= w_commit_fire;
            // A commit command landing on the firing edge is absorbed into that commit.
            if (w_commit_fire) begin
                r_commit_pend <= 1'b0;
            end else if (w_wr_done && w_is_cmd) begin
                r_commit_pend <= 1'b1;
            end
        end
    end

    // Shadow and active banks; active copies the pre-write shadow on a coincident write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_flags  <= '0;
            r_act_flags <= '0;
            for (int i = 0; i < N_WORD; i++) begin
                r_sh_words[i]  <= '0;
                r_act_words[i] <= '0;
            end
        end else begin
            if (w_wr_done && w_is_flag) begin
                r_sh_flags[w_flag_idx] <= r_wdata[0];
            end
            if (w_wr_done && w_is_word) begin
                r_sh_words[w_word_idx] <= r_wdata;
            end
            if (w_commit_fire) begin
                r_act_flags <= r_sh_flags;
                for (int i = 0; i < N_WORD; i++) begin
                    r_act_words[i] <= r_sh_words[i];
                end
            end
        end
    end

    for (genvar g = 0; g < N_WORD; g++) begin : g_words
        assign cfg_words[32*g +: 32] = r_act_words[g];
    end

    assign cfg_flags   = r_act_flags;
    assign vme_ack     = r_ack;
    assign vme_err     = r_err;
    assign vme_rdata   = r_rdata;
    assign cfg_valid   = r_cfg_valid;
    assign commit_pend = r_commit_pend;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_vme_reg_sched.sv
// tb/tb_vme_reg_sched.sv - directed table-driven bench for vme_reg_sched
module tb_vme_reg_sched;

    localparam int N_FLAG = 15;
    localparam int N_WORD = 58;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 vme_req = 1'b0;
    logic                 vme_wr = 1'b0;
    logic [6:0]           vme_addr = '0;
    logic [31:0]          vme_wdata = '0;
    logic                 vme_ack;
    logic                 vme_err;
    logic [31:0]          vme_rdata;
    logic                 spill_gate = 1'b0;
    logic [N_FLAG-1:0]    cfg_flags;
    logic [N_WORD*32-1:0] cfg_words;
    logic                 cfg_valid;
    logic                 commit_pend;
    logic                 busy;

    vme_reg_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vme_req     (vme_req),
        .vme_wr      (vme_wr),
        .vme_addr    (vme_addr),
        .vme_wdata   (vme_wdata),
        .vme_ack     (vme_ack),
        .vme_err     (vme_err),
        .vme_rdata   (vme_rdata),
        .spill_gate  (spill_gate),
        .cfg_flags   (cfg_flags),
        .cfg_words   (cfg_words),
        .cfg_valid   (cfg_valid),
        .commit_pend (commit_pend),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;

    always @(negedge clk) begin
        if (cfg_valid) valid_cnt <= valid_cnt + 1;
    end

    typedef struct {
        logic        spill;
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int i);
        return cfg_words[32*i +: 32];
    endfunction

    task automatic access(input logic wr, input logic [6:0] addr, input logic [31:0] data,
                          output int lat, output logic err, output logic [31:0] rdata);
        int  n;
        bit  got;
        @(negedge clk);
        vme_req = 1'b1; vme_wr = wr; vme_addr = addr; vme_wdata = data;
        n = 0; got = 0; lat = -1; err = 1'bx; rdata = 'x;
        while (!got && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (vme_ack) begin
                got = 1; lat = n - 1; err = vme_err; rdata = vme_rdata;
            end
        end
        vme_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ack_one_cycle", {31'b0, vme_ack}, 32'd0);
    endtask

    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          v0;
    int          ack_seen;

    initial begin
        tbl[0]  = '{0, 1, 7'd20,  32'hDEADBEEF, 0, 32'h0,        1};
        tbl[1]  = '{0, 0, 7'd20,  32'h0,        0, 32'hDEADBEEF, 2};
        tbl[2]  = '{0, 1, 7'd3,   32'hFFFFFFFE, 0, 32'h0,        1};
        tbl[3]  = '{0, 0, 7'd3,   32'h0,        0, 32'h0,        2};
        tbl[4]  = '{0, 1, 7'd3,   32'h1,        0, 32'h0,        1};
        tbl[5]  = '{0, 0, 7'd3,   32'h0,        0, 32'h1,        2};
        tbl[6]  = '{0, 1, 7'd15,  32'h11111111, 0, 32'h0,        1};
        tbl[7]  = '{0, 1, 7'd72,  32'hA5A5A5A5, 0, 32'h0,        1};
        tbl[8]  = '{0, 0, 7'd72,  32'h0,        0, 32'hA5A5A5A5, 2};
        tbl[9]  = '{0, 1, 7'd14,  32'h1,        0, 32'h0,        1};
        tbl[10] = '{0, 0, 7'd14,  32'h0,        0, 32'h1,        2};
        tbl[11] = '{1, 1, 7'h7F,  32'h0,        0, 32'h0,        1};
        tbl[12] = '{1, 0, 7'h7E,  32'h0,        0, 32'h3,        2};
        tbl[13] = '{1, 1, 7'd100, 32'hCAFEF00D, 1, 32'h0,        1};
        tbl[14] = '{1, 0, 7'd100, 32'h0,        1, 32'h0,        2};
        tbl[15] = '{1, 1, 7'h7E,  32'h12345678, 1, 32'h0,        1};
        tbl[16] = '{1, 0, 7'h7F,  32'h0,        1, 32'h0,        2};
        tbl[17] = '{1, 1, 7'd73,  32'h87654321, 1, 32'h0,        1};
        tbl[18] = '{1, 0, 7'd73,  32'h0,        1, 32'h0,        2};
        tbl[19] = '{1, 0, 7'd20,  32'h0,        0, 32'hDEADBEEF, 2};
        tbl[20] = '{1, 0, 7'd3,   32'h0,        0, 32'h1,        2};
        tbl[21] = '{1, 0, 7'h7E,  32'h0,        0, 32'h3,        2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",   {31'b0, vme_ack},     32'd0);
        chk("rst_err",   {31'b0, vme_err},     32'd0);
        chk("rst_rdata", vme_rdata,            32'd0);
        chk("rst_valid", {31'b0, cfg_valid},   32'd0);
        chk("rst_pend",  {31'b0, commit_pend}, 32'd0);
        chk("rst_busy",  {31'b0, busy},        32'd0);
        chk("rst_flags", {17'b0, cfg_flags},   32'd0);
        chk("rst_words_zero", {31'b0, (cfg_words == '0)}, 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            spill_gate = tbl[i].spill;
            access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, lat, err, rdata);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
            if (!tbl[i].wr) chk($sformatf("v%0d_rdata", i), rdata, tbl[i].exp_rdata);
        end

        chk("spill_no_valid", 32'(valid_cnt), 32'd0);
        chk("spill_pend",  {31'b0, commit_pend}, 32'd1);
        chk("spill_word5", word_of(5), 32'd0);
        chk("spill_flags", {17'b0, cfg_flags}, 32'd0);

        // Drop spill gate: pending commit fires on the next edge.
        v0 = valid_cnt;
        spill_gate = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("commit_valid", {31'b0, cfg_valid},   32'd1);
        chk("commit_pend0", {31'b0, commit_pend}, 32'd0);
        chk("commit_word5", word_of(5),  32'hDEADBEEF);
        chk("commit_word0", word_of(0),  32'h11111111);
        chk("commit_word57", word_of(57), 32'hA5A5A5A5);
        chk("commit_flags", {17'b0, cfg_flags}, 32'h4008);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("commit_single", 32'(valid_cnt - v0), 32'd1);
        access(1'b0, 7'h7E, 32'h0, lat, err, rdata);
        chk("status_idle", rdata, 32'd0);

        // Shadow write on the same edge as the commit copy.
        spill_gate = 1'b1;
        access(1'b1, 7'h7F, 32'h0, lat, err, rdata);
        chk("pend_again", {31'b0, commit_pend}, 32'd1);
        @(negedge clk);
        vme_req = 1'b1; vme_wr = 1'b1; vme_addr = 7'd15; vme_wdata = 32'h1234;
        @(posedge clk);
        @(negedge clk);
        spill_gate = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("same_ack",   {31'b0, vme_ack},     32'd1);
        chk("same_valid", {31'b0, cfg_valid},   32'd1);
        chk("same_word0", word_of(0),           32'h11111111);
        chk("same_pend",  {31'b0, commit_pend}, 32'd0);
        vme_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        access(1'b0, 7'd15, 32'h0, lat, err, rdata);
        chk("same_shadow", rdata, 32'h1234);
        chk("same_word0_hold", word_of(0), 32'h11111111);

        // Commit with spill low: copy lands on the edge after the write ack.
        v0 = valid_cnt;
        access(1'b1, 7'h7F, 32'h0, lat, err, rdata);
        chk("commit2_valid", {31'b0, cfg_valid},   32'd1);
        chk("commit2_word0", word_of(0),           32'h1234);
        chk("commit2_pend",  {31'b0, commit_pend}, 32'd0);

        // Reset while the read is waiting.
        @(negedge clk);
        vme_req = 1'b1; vme_wr = 1'b0; vme_addr = 7'd20;
        @(posedge clk);
        @(negedge clk);
        chk("rdwait_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_ack",   {31'b0, vme_ack},     32'd0);
        chk("mid_rdata", vme_rdata,            32'd0);
        chk("mid_busy",  {31'b0, busy},        32'd0);
        chk("mid_pend",  {31'b0, commit_pend}, 32'd0);
        chk("mid_valid", {31'b0, cfg_valid},   32'd0);
        chk("mid_flags", {17'b0, cfg_flags},   32'd0);
        chk("mid_words_zero", {31'b0, (cfg_words == '0)}, 32'd1);
        vme_req = 1'b0;
        ack_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (vme_ack) ack_seen++;
        end
        chk("mid_no_ack", 32'(ack_seen), 32'd0);
        rst_n = 1'b1;

        access(1'b0, 7'd20, 32'h0, lat, err, rdata);
        chk("post_lat",   32'(lat), 32'd2);
        chk("post_err",   {31'b0, err}, 32'd0);
        chk("post_rdata", rdata, 32'd0);
        access(1'b1, 7'd20, 32'h5A5A5A5A, lat, err, rdata);
        chk("post_wr_lat", 32'(lat), 32'd1);
        access(1'b0, 7'd20, 32'h0, lat, err, rdata);
        chk("post_rd2", rdata, 32'h5A5A5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
